// File: rtl/ksa_stream_accum.sv
// Frame accumulator: sums a valid/ready stream of 32-bit operands per frame through a
// 32-bit Kogge-Stone adder and emits one {sum, beat count, overflow} result per frame.

module UBKSA_31_0_31_0 (
  input  logic [31:0] X,
  input  logic [31:0] Y,
  output logic [32:0] S
);

  logic [31:0] g0;
  logic [31:0] p0;
  logic [31:0] g_final;

  assign g0 = X & Y;
  assign p0 = X ^ Y;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : lvl
      localparam int D = 1 << gi;
      logic [31:0] g_in;
      logic [31:0] p_in;
      logic [31:0] g_out;
      logic [31:0] p_out;
      if (gi == 0) begin : src
        assign g_in = g0;
        assign p_in = p0;
      end else begin : src
        assign g_in = lvl[gi-1].g_out;
        assign p_in = lvl[gi-1].p_out;
      end
      // Combine each bit with the prefix D positions below; low D bits are already final.
      assign g_out = g_in | (p_in & {g_in[31-D:0], {D{1'b0}}});
      assign p_out = p_in & {p_in[31-D:0], {D{1'b1}}};
    end
  endgenerate

  assign g_final = lvl[4].g_out;
  // Carry-in is zero, so the carry into bit i is the group generate of bits [i-1:0].
  assign S = {g_final[31], p0 ^ {g_final[30:0], 1'b0}};

endmodule

module ksa_stream_accum #(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [32+CNT_W-1:0] out_sum,
  output logic [CNT_W-1:0]    out_count,
  output logic                out_ovf
);

  typedef enum logic {ACCUM = 1'b0, OUT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_reg;
  state_t           state_next;
  logic             pipe_valid_reg;
  logic [31:0]      pipe_data_reg;
  logic             pipe_last_reg;
  logic [31:0]      acc_lo_reg;
  logic [CNT_W-1:0] acc_hi_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             ovf_reg;

  logic             pipe_consume;
  logic [32:0]      sum;
  logic [31:0]      acc_lo_next;
  logic [CNT_W-1:0] acc_hi_next;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_next;
  logic             cnt_max;

  UBKSA_31_0_31_0 u_add (
    .X(acc_lo_reg),
    .Y(pipe_data_reg),
    .S(sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ACCUM;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ACCUM:   if (pipe_consume && pipe_last_reg) state_next = OUT;
      OUT:     if (out_ready) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_comb begin
    pipe_consume = pipe_valid_reg && (state_reg == ACCUM);
    in_ready     = !pipe_valid_reg || pipe_consume;
  end

  always_comb begin
    acc_lo_next = sum[31:0];
    acc_hi_next = acc_hi_reg + {{(CNT_W-1){1'b0}}, sum[32]};
    cnt_max     = (cnt_reg == CNT_MAX);
    cnt_next    = cnt_max ? cnt_reg : cnt_reg + CNT_W'(1);
    ovf_next    = ovf_reg | cnt_max;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid_reg <= 1'b0;
      pipe_data_reg  <= '0;
      pipe_last_reg  <= 1'b0;
    end else if (in_valid && in_ready) begin
      pipe_valid_reg <= 1'b1;
      pipe_data_reg  <= in_data;
      pipe_last_reg  <= in_last;
    end else if (pipe_consume) begin
      pipe_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_lo_reg <= '0;
      acc_hi_reg <= '0;
      cnt_reg    <= '0;
      ovf_reg    <= 1'b0;
    end else if (pipe_consume) begin
      if (pipe_last_reg) begin
        acc_lo_reg <= '0;
        acc_hi_reg <= '0;
        cnt_reg    <= '0;
        ovf_reg    <= 1'b0;
      end else begin
        acc_lo_reg <= acc_lo_next;
        acc_hi_reg <= acc_hi_next;
        cnt_reg    <= cnt_next;
        ovf_reg    <= ovf_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (pipe_consume && pipe_last_reg) begin
      out_valid <= 1'b1;
      out_sum   <= {acc_hi_next, acc_lo_next};
      out_count <= cnt_next;
      out_ovf   <= ovf_next;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
